// File: rtl/reg_fpga_pkg.sv
// Shared constants and parameter helpers for the reg_pipe_fpga pipeline register.
package reg_fpga_pkg;

   localparam int NIB_W = 4;

   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Legal configurations: room for the top-nibble tap and at least one stage.
   function automatic bit params_ok(input int n, input int depth);
      return (n >= NIB_W) && (depth >= 1);
   endfunction

endpackage

// File: rtl/reg_stage_fpga.sv
// One pipeline stage: data word, top-nibble tap and valid bit.
module reg_stage_fpga
   import reg_fpga_pkg::*;
#(
   parameter int N = 64
) (
   input  logic             CLK,
   input  logic             R,
   input  logic             load,
   input  logic             clear,
   input  logic             up_valid,
   input  logic [N-1:0]     up_data,
   input  logic [NIB_W-1:0] up_nib,
   output logic             v,
   output logic [N-1:0]     data,
   output logic [NIB_W-1:0] nib
);

   // Payload only moves with a valid word, so a bubble never overwrites held data.
   always_ff @(posedge CLK) begin
      if (R) begin
         v    <= 1'b0;
         data <= '0;
         nib  <= '0;
      end else if (clear) begin
         v <= 1'b0;
      end else if (load) begin
         v <= up_valid;
         if (up_valid) begin
            data <= up_data;
            nib  <= up_nib;
         end
      end
   end

endmodule

// File: rtl/reg_pipe_fpga.sv
// Collapsing valid/ready pipeline register with enable, flush, occupancy count and nibble tap.
module reg_pipe_fpga
   import reg_fpga_pkg::*;
#(
   parameter int N     = 64,
   parameter int DEPTH = 4
) (
   input  logic                        CLK,
   input  logic                        R,
   input  logic                        E,
   input  logic                        FLUSH,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N-1:0]                data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N-1:0]                q,
   output logic [NIB_W-1:0]            q3,
   output logic [count_w(DEPTH)-1:0]   count
);

   localparam int CW = count_w(DEPTH);

   if (!params_ok(N, DEPTH)) begin : g_bad_params
      $error("reg_pipe_fpga: need N >= 4 and DEPTH >= 1");
   end

   logic             run;
   logic             in_hs;
   logic             out_hs;
   logic [DEPTH-1:0] mv;
   logic [DEPTH-1:0] v;
   logic [N-1:0]     sd [DEPTH];
   logic [NIB_W-1:0] sn [DEPTH];

   assign run = E & !FLUSH;

   // A stage may advance when it is empty or everything downstream of it advances.
   always_comb begin
      mv = '0;
      mv[DEPTH-1] = !v[DEPTH-1] | out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         mv[i] = !v[i] | mv[i+1];
      end
   end

   assign in_ready = run & mv[0];
   assign in_hs    = in_valid & in_ready;
   assign out_hs   = v[DEPTH-1] & out_ready & run;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             up_valid;
      logic [N-1:0]     up_data;
      logic [NIB_W-1:0] up_nib;

      if (i == 0) begin : g_head
         assign up_valid = in_hs;
         assign up_data  = data;
         assign up_nib   = data[N-1 -: NIB_W];
      end else begin : g_link
         assign up_valid = v[i-1];
         assign up_data  = sd[i-1];
         assign up_nib   = sn[i-1];
      end

      reg_stage_fpga #(.N(N)) u_stage (
         .CLK      (CLK),
         .R        (R),
         .load     (run & mv[i]),
         .clear    (E & FLUSH),
         .up_valid (up_valid),
         .up_data  (up_data),
         .up_nib   (up_nib),
         .v        (v[i]),
         .data     (sd[i]),
         .nib      (sn[i])
      );
   end

   // Occupancy tracks handshakes rather than counting valid bits.
   always_ff @(posedge CLK) begin
      if (R) begin
         count <= '0;
      end else if (E & FLUSH) begin
         count <= '0;
      end else if (in_hs & !out_hs) begin
         count <= count + CW'(1);
      end else if (out_hs & !in_hs) begin
         count <= count - CW'(1);
      end
   end

   assign q         = sd[DEPTH-1];
   assign q3        = sn[DEPTH-1];
   assign out_valid = v[DEPTH-1];

endmodule
